// File: rtl/ap_mac_acc_8b.sv
// ap_mac_acc_8b: saturating accumulator summing a programmable count of signed products behind valid/ready handshakes
module ap_mac_acc_8b #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             prod_vld,
  output logic             prod_rdy,
  input  logic [15:0]      prod,
  output logic             res_vld,
  input  logic             res_rdy,
  output logic [ACC_W-1:0] res,
  output logic             sat,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  state_t state;
  logic [ACC_W-1:0] acc;
  logic [LEN_W-1:0] cnt;
  logic [ACC_W:0] sum;
  logic ovf;
  logic [ACC_W-1:0] clamp;
  assign sum = {acc[ACC_W-1], acc} + {{(ACC_W-15){prod[15]}}, prod};
  // overflow whenever the two top bits of the widened sum disagree
  assign ovf = sum[ACC_W] ^ sum[ACC_W-1];
  assign clamp = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  assign res = acc;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      sat <= 1'b0;
      prod_rdy <= 1'b0;
      res_vld <= 1'b0;
      busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          acc <= '0;
          sat <= 1'b0;
          cnt <= len;
          busy <= 1'b1;
          state <= (len != '0) ? ACC : DONE;
          prod_rdy <= len != '0;
          res_vld <= len == '0;
        end
        ACC: if (prod_vld) begin
          acc <= ovf ? clamp : sum[ACC_W-1:0];
          sat <= sat | ovf;
          cnt <= cnt - LEN_W'(1);
          if (cnt == LEN_W'(1)) begin
            state <= DONE;
            prod_rdy <= 1'b0;
            res_vld <= 1'b1;
          end
        end
        DONE: if (res_rdy) begin
          state <= IDLE;
          res_vld <= 1'b0;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ap_mac_acc_8b.sv
// tb_ap_mac_acc_8b: scoreboard bench for the accumulator at ACC_W=17 so both clamp rails are reachable
module tb_ap_mac_acc_8b;
  localparam int AW = 17;
  localparam int LW = 8;
  logic clk = 0, rst_n = 0, start = 0, prod_vld = 0, res_rdy = 0;
  logic [LW-1:0] len = '0;
  logic [15:0] prod = '0;
  logic prod_rdy, res_vld, sat, busy;
  logic signed [AW-1:0] res;
  logic [AW:0] sb[$];
  logic [AW:0] exp_v;
  int checks = 0, errors = 0;

  ap_mac_acc_8b #(.ACC_W(AW), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .prod_vld(prod_vld),
    .prod_rdy(prod_rdy), .prod(prod), .res_vld(res_vld), .res_rdy(res_rdy),
    .res(res), .sat(sat), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [AW:0] model(input int p[$]);
    longint a = 0;
    logic s = 0;
    foreach (p[i]) begin
      a += p[i];
      if (a > 65535) begin a = 65535; s = 1; end
      if (a < -65536) begin a = -65536; s = 1; end
    end
    return {s, AW'(a)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int l);
    start = 1; len = LW'(l);
    tick;
    start = 0;
  endtask

  task automatic handshake;
    res_rdy = 1;
    tick;
    res_rdy = 0;
  endtask

  task automatic test_reset;
    rst_n = 0;
    for (int i = 0; i < 3; i++) begin
      start = 1'($urandom); len = LW'($urandom); prod_vld = 1'($urandom);
      prod = 16'($urandom); res_rdy = 1'($urandom);
      tick;
    end
    checks++;
    if ({prod_rdy, res_vld, res, sat, busy} !== '0) begin
      errors++;
      $display("FAIL reset got rdy=%b vld=%b res=%0d sat=%b busy=%b want all 0", prod_rdy, res_vld, res, sat, busy);
    end
    start = 0; prod_vld = 0; res_rdy = 0; rst_n = 1;
    tick;
  endtask

  task automatic test_basic;
    int p[$] = '{100, -50, 16384, -1};
    sb.push_back(model(p));
    do_start(4);
    checks++;
    if (prod_rdy !== 1 || busy !== 1) begin
      errors++; $display("FAIL basic_acc_state got rdy=%b busy=%b want 1 1", prod_rdy, busy);
    end
    foreach (p[i]) begin
      prod_vld = 1; prod = 16'(p[i]);
      tick;
      checks++;
      if (res_vld !== (i == 3)) begin
        errors++; $display("FAIL basic_latency after accept %0d got vld=%b want %b", i, res_vld, i == 3);
      end
    end
    prod_vld = 0;
    tick; tick;
    exp_v = sb.pop_front();
    checks++;
    if (res_vld !== 1 || {sat, res} !== exp_v) begin
      errors++; $display("FAIL basic_res got vld=%b sat=%b res=%0d want 1 %b %0d", res_vld, sat, res, exp_v[AW], $signed(exp_v[AW-1:0]));
    end
    handshake;
    checks++;
    if (res_vld !== 0 || busy !== 0) begin
      errors++; $display("FAIL basic_release got vld=%b busy=%b want 0 0", res_vld, busy);
    end
  endtask

  task automatic test_stall;
    int p[$] = '{7, 8, 9};
    bit pat[6] = '{1, 0, 0, 1, 0, 1};
    int k = 0;
    sb.push_back(model(p));
    do_start(3);
    for (int i = 0; i < 6; i++) begin
      prod_vld = pat[i]; prod = 16'(p[k]);
      checks++;
      if (prod_rdy !== 1) begin
        errors++; $display("FAIL stall_rdy cycle %0d got %b want 1", i, prod_rdy);
      end
      tick;
      if (pat[i]) k++;
    end
    exp_v = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      prod_vld = 1'(i); prod = 16'd1000;
      checks++;
      if (res_vld !== 1 || prod_rdy !== 0 || {sat, res} !== exp_v) begin
        errors++; $display("FAIL stall_hold cycle %0d got vld=%b rdy=%b res=%0d want 1 0 %0d", i, res_vld, prod_rdy, res, $signed(exp_v[AW-1:0]));
      end
      tick;
    end
    prod_vld = 0;
    handshake;
  endtask

  task automatic test_len0;
    int p[$];
    sb.push_back(model(p));
    do_start(0);
    exp_v = sb.pop_front();
    checks++;
    if (res_vld !== 1 || prod_rdy !== 0 || {sat, res} !== exp_v) begin
      errors++; $display("FAIL len0 got vld=%b rdy=%b sat=%b res=%0d want 1 0 0 0", res_vld, prod_rdy, sat, res);
    end
    start = 1; len = 8'd3;
    handshake;
    start = 0;
    tick;
    checks++;
    if (busy !== 0 || res_vld !== 0) begin
      errors++; $display("FAIL start_on_handshake got busy=%b vld=%b want 0 0", busy, res_vld);
    end
  endtask

  task automatic test_ignored_start;
    int p[$] = '{3, 4};
    sb.push_back(model(p));
    do_start(2);
    prod_vld = 1; prod = 16'd3;
    tick;
    prod_vld = 0; start = 1; len = 8'd9;
    tick;
    start = 0; prod_vld = 1; prod = 16'd4;
    tick;
    prod_vld = 0;
    exp_v = sb.pop_front();
    checks++;
    if (res_vld !== 1 || {sat, res} !== exp_v) begin
      errors++; $display("FAIL ignored_start got vld=%b res=%0d want 1 %0d", res_vld, res, $signed(exp_v[AW-1:0]));
    end
    handshake;
  endtask

  task automatic run_vec(input string name, input int p[$]);
    sb.push_back(model(p));
    do_start(p.size());
    foreach (p[i]) begin
      prod_vld = 1; prod = 16'(p[i]);
      tick;
    end
    prod_vld = 0;
    exp_v = sb.pop_front();
    checks++;
    if (res_vld !== 1 || {sat, res} !== exp_v) begin
      errors++; $display("FAIL %s got vld=%b sat=%b res=%0d want 1 %b %0d", name, res_vld, sat, res, exp_v[AW], $signed(exp_v[AW-1:0]));
    end
    handshake;
  endtask

  task automatic test_saturation;
    run_vec("sat_pos", '{16384, 16384, 16384, 16384, 16384, -16384});
    run_vec("sat_neg", '{-16384, -16384, -16384, -16384, -16384, -16384});
    run_vec("exact_min", '{-16384, -16384, -16384, -16384});
    run_vec("mixed", '{-32768, 32767, -1, 12345});
  endtask

  task automatic test_reset_mid;
    do_start(4);
    prod_vld = 1; prod = 16'd11;
    tick; tick;
    prod_vld = 0; rst_n = 0;
    tick;
    rst_n = 1;
    checks++;
    if (busy !== 0 || prod_rdy !== 0 || res_vld !== 0 || res !== 0 || sat !== 0) begin
      errors++; $display("FAIL reset_mid got busy=%b rdy=%b vld=%b res=%0d want 0 0 0 0", busy, prod_rdy, res_vld, res);
    end
    tick;
    run_vec("restart", '{5});
  endtask

  task automatic test_back_to_back;
    run_vec("b2b_a", '{1, 2, 3});
    tick;
    run_vec("b2b_b", '{-7, 300});
  endtask

  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_len0;
    test_ignored_start;
    test_saturation;
    test_reset_mid;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ap_mac_acc_8b.md
# ap_mac_acc_8b

Sequential accumulate stage that sits directly downstream of the approximate signed 8×8 radix-4 Wallace multiplier. It consumes the multiplier's 16-bit signed product stream through a valid/ready handshake and sums a programmable number of products into a saturating accumulator. It then presents the dot-product result through a second valid/ready handshake. Together with the multiplier it forms the MAC datapath used for error-resilient dot-product evaluation.

## Interface
- ACC_W, 24: accumulator and result width in bits; must be ≥ 17.
- LEN_W, 8: width of the vector-length field.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  one-cycle request to begin a new accumulation; sampled only in IDLE.
- len  in  LEN_W  number of products to accumulate (unsigned); sampled with start.
- prod_vld  in  1  product valid from the upstream multiplier path.
- prod_rdy  out  1  this block accepts a product this cycle.
- prod  in  16  signed product, i.e. the multiplier `res`.
- res_vld  out  1  result valid.
- res_rdy  in  1  downstream accepts result.
- res  out  ACC_W  signed accumulated result.
- sat  out  1  at least one add in this accumulation clamped; valid with res_vld.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, ACC, DONE.
- IDLE:
  - prod_rdy=0, res_vld=0, busy=0.
  - On start=1 with len≠0: clear acc and sat, load cnt=len, go to ACC.
  - On start=1 with len=0: clear acc and sat, go directly to DONE. The result is 0 and sat is 0.
- ACC:
  - prod_rdy=1, busy=1.
  - A product is accepted when prod_vld & prod_rdy.
  - On acceptance: acc ← sat_clamp(acc + sign_ext(prod)) and cnt ← cnt−1.
  - If cnt was 1 before the decrement, go to DONE.
  - Without prod_vld, acc and cnt hold indefinitely.
- DONE:
  - res_vld=1, prod_rdy=0, busy=1.
  - res=acc and sat are held stable until res_vld & res_rdy.
  - On that handshake, go to IDLE.
- Arithmetic:
  - The sum is formed at ACC_W+1 bits.
  - If the sum exceeds 2^(ACC_W−1)−1 it clamps to that value; if below −2^(ACC_W−1) it clamps to that value. Either case sets sat.
  - sat is sticky until the next start.
  - Accumulation continues from the clamped value.
- start is ignored in ACC and DONE, and len is not re-sampled there.
- res and sat outputs drive directly from the acc and sat registers; there is no combinational path from inputs to outputs.

## Timing
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, acc=0, cnt=0, sat=0.
  - prod_rdy=0, res_vld=0, res=0, busy=0.
  - Reset applied mid-ACC or mid-DONE abandons the operation; no result is emitted.
- start accepted at edge t:
  - state=ACC and prod_rdy=1 from cycle t+1.
  - If len=0, res_vld=1 from cycle t+1 instead.
- Throughput: one product per cycle while prod_vld stays high.
- Latency: for N back-to-back products with the first accepted at edge t1, the last is accepted at edge t1+N−1. res_vld rises in the following cycle.
- Result is presented one cycle after the last accepted product; res_vld held for ≥1 cycle.
- DONE→IDLE on the res handshake edge. A new start is accepted no earlier than the next edge, giving a minimum 1 idle cycle between results.
- start asserted in the same cycle as the DONE handshake is ignored.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with random inputs -> prod_rdy=0, res_vld=0, res=0, sat=0, busy=0.
- Basic dot product: start, len=4; products 100, −50, 16384, −1 back-to-back -> res_vld rises 1 cycle after the 4th accept; res=16433, sat=0; holds until res_rdy=1.
- Stalls and backpressure: len=3, prod_vld toggles 1,0,0,1,0,1 with products 7, 8, 9; res_rdy held 0 for 5 cycles -> res=24 stable throughout, prod_rdy=0 in DONE, extra prod_vld pulses ignored.
- len=0 and ignored start: start with len=0 -> res_vld next cycle, res=0; a start pulse during ACC of a len=2 run does not alter cnt or acc.
- Saturation with ACC_W=17: len=6, products 16384 ×5 then −16384 -> clamp at 65535, sat=1, final res=49151. Negative mirror (−16384 ×6) -> res=−65536, sat=1.
- Reset mid-operation: rst_n low after 2 of 4 products accepted -> IDLE next edge. Restart with len=1, product 5 -> res=5, sat=0.
